// File: rtl/sys_arr_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sys_arr_feeder
// Brief    : Loads a weight tile into a WxW systolic array, then streams
//            diagonally skewed data vectors into it.
// Revision : 1.0
// ============================================================================
module sys_arr_feeder #(
  parameter int width_height = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      wvalid,
  input  logic [8*width_height-1:0] wrow,
  output logic                      wready,
  input  logic                      dvalid,
  input  logic [8*width_height-1:0] drow,
  input  logic                      dlast,
  output logic                      dready,
  output logic [8*width_height-1:0] win,
  output logic [width_height-1:0]   wwrite,
  output logic [8*width_height-1:0] datain,
  output logic                      active,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = $clog2(width_height) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(width_height - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [8*width_height-1:0] win_q, win_d;
  logic [width_height-1:0]   wwrite_q, wwrite_d;
  logic                      active_q, active_d;
  logic                      done_q, done_d;

  logic                      w_wtake;
  logic                      w_dtake;
  logic [width_height-1:0]   w_out_vld_d;

  assign wready  = (state_q == LOAD_W);
  assign dready  = (state_q == STREAM);
  assign busy    = (state_q != IDLE);
  assign w_wtake = wvalid & wready;
  assign w_dtake = dvalid & dready;

  assign win    = win_q;
  assign wwrite = wwrite_q;
  assign active = active_q;
  assign done   = done_q;

  // One counter serves both phases: weight rows in LOAD_W, drain cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          cnt_d   = '0;
        end
      end
      LOAD_W: begin
        if (w_wtake) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STREAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      STREAM: begin
        if (w_dtake && dlast) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    win_d    = w_wtake ? wrow : win_q;
    wwrite_d = w_wtake ? {width_height{1'b1}} : {width_height{1'b0}};
    active_d = |w_out_vld_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= '0;
      wwrite_q <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      wwrite_q <= wwrite_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // Lane i is an (i+1)-deep shift register; idle cycles inject zero bubbles.
  for (genvar i = 0; i < width_height; i++) begin : g_lane
    logic [7:0] dat_q [0:i];
    logic [7:0] dat_d [0:i];
    logic [i:0] vld_q, vld_d;

    always_comb begin
      dat_d[0] = w_dtake ? drow[8*i +: 8] : 8'h00;
      vld_d[0] = w_dtake;
      for (int s = 1; s <= i; s++) begin
        dat_d[s] = dat_q[s-1];
        vld_d[s] = vld_q[s-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
        for (int s = 0; s <= i; s++) begin
          dat_q[s] <= 8'h00;
        end
      end else begin
        vld_q <= vld_d;
        for (int s = 0; s <= i; s++) begin
          dat_q[s] <= dat_d[s];
        end
      end
    end

    assign datain[8*i +: 8] = dat_q[i];
    assign w_out_vld_d[i]   = vld_d[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_arr_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_arr_feeder
// Brief    : Directed self-checking bench for sys_arr_feeder with W=4.
// Revision : 1.0
// ============================================================================
module tb_sys_arr_feeder;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          wvalid;
  logic [8*W-1:0] wrow;
  logic          wready;
  logic          dvalid;
  logic [8*W-1:0] drow;
  logic          dlast;
  logic          dready;
  logic [8*W-1:0] win;
  logic [W-1:0]  wwrite;
  logic [8*W-1:0] datain;
  logic          active;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [31:0] t_din [10];
  logic [31:0] t_exp [10];
  logic        t_v   [10];
  logic        t_l   [10];
  logic        t_a   [10];

  sys_arr_feeder #(.width_height(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .wvalid (wvalid),
    .wrow   (wrow),
    .wready (wready),
    .dvalid (dvalid),
    .drow   (drow),
    .dlast  (dlast),
    .dready (dready),
    .win    (win),
    .wwrite (wwrite),
    .datain (datain),
    .active (active),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Loads four rows (row k at rows[32k+:32]); optional one-cycle wvalid gap after row gap_after.
  task automatic load_job(input bit do_start, input logic [127:0] rows, input int gap_after);
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    check("busy_load", busy, 1);
    check("wready_load", wready, 1);
    for (int k = 0; k < 4; k++) begin
      wvalid = 1'b1;
      wrow   = rows[32*k +: 32];
      step();
      check("win_row", win, rows[32*k +: 32]);
      check("wwrite_row", wwrite, 4'hf);
      check("wready_row", wready, (k != 3));
      check("dready_row", dready, (k == 3));
      if (k == gap_after) begin
        wvalid = 1'b0;
        wrow   = 32'hffff_ffff;
        step();
        check("wwrite_gap", wwrite, 4'h0);
        check("win_gap", win, rows[32*k +: 32]);
        check("wready_gap", wready, 1);
      end
    end
    wvalid = 1'b0;
    wrow   = '0;
  endtask

  // Drives t_* tables for nsteps edges and checks datain/active/done/busy after each.
  task automatic stream(input int nsteps, input int done_idx, input int start_at);
    for (int j = 0; j < nsteps; j++) begin
      dvalid = t_v[j];
      dlast  = t_l[j];
      drow   = t_din[j];
      start  = (j == start_at);
      step();
      check($sformatf("datain_%0d", j), datain, t_exp[j]);
      check($sformatf("active_%0d", j), active, t_a[j]);
      check($sformatf("done_%0d", j), done, (j == done_idx));
      check($sformatf("busy_%0d", j), busy, (j < done_idx));
    end
    dvalid = 1'b0;
    dlast  = 1'b0;
    drow   = '0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    wvalid = 1'b0;
    wrow   = '0;
    dvalid = 1'b0;
    drow   = '0;
    dlast  = 1'b0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_datain", datain, 0);
    check("rst_wready", wready, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    step();
    check("idle_busy", busy, 0);

    // Job 1: four back-to-back vectors, start pulsed during STREAM must be ignored.
    load_job(1'b1, {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404}, -1);
    t_v   = '{0:1, 1:1, 2:1, 3:1, default:0};
    t_l   = '{3:1, default:0};
    t_din = '{0:32'h01010101, 1:32'h01010101, 2:32'h01010101, 3:32'h01010101, default:32'h0};
    t_exp = '{0:32'h00000001, 1:32'h00000101, 2:32'h00010101, 3:32'h01010101,
              4:32'h01010100, 5:32'h01010000, 6:32'h01000000, default:32'h0};
    t_a   = '{0:1, 1:1, 2:1, 3:1, 4:1, 5:1, 6:1, default:0};
    stream(9, 7, 1);
    start = 1'b0;
    check("job1_idle", busy, 0);

    // Job 2: weight gap, then a bubble between vectors with dlast high while dvalid low.
    load_job(1'b1, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1);
    t_v   = '{0:1, 2:1, default:0};
    t_l   = '{1:1, 2:1, default:0};
    t_din = '{0:32'h04030201, 1:32'hdeadbeef, 2:32'h08070605, default:32'h0};
    t_exp = '{0:32'h00000001, 1:32'h00000200, 2:32'h00030005, 3:32'h04000600,
              4:32'h00070000, 5:32'h08000000, default:32'h0};
    t_a   = '{0:1, 1:1, 2:1, 3:1, 4:1, 5:1, default:0};
    stream(7, 6, 6);

    // start held across the IDLE re-entry edge is taken on the next edge.
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_wready", wready, 1);
    check("restart_datain", datain, 0);

    // Job 3: single-vector job.
    load_job(1'b0, {32'h0d0d0d0d, 32'h0c0c0c0c, 32'h0b0b0b0b, 32'h0a0a0a0a}, -1);
    t_v   = '{0:1, default:0};
    t_l   = '{0:1, default:0};
    t_din = '{0:32'ha0b0c0d0, default:32'h0};
    t_exp = '{0:32'h000000d0, 1:32'h0000c000, 2:32'h00b00000, 3:32'ha0000000, default:32'h0};
    t_a   = '{0:1, 1:1, 2:1, 3:1, default:0};
    stream(6, 4, -1);

    // Job 4: reset asserted mid-STREAM between clock edges.
    load_job(1'b1, {32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808}, -1);
    dvalid = 1'b1;
    drow   = 32'h05050505;
    step();
    step();
    check("pre_rst_datain", datain, 32'h00000505);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_win", win, 0);
    check("mid_rst_wwrite", wwrite, 0);
    check("mid_rst_datain", datain, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_wready", wready, 0);
    check("mid_rst_dready", dready, 0);
    dvalid = 1'b0;
    drow   = '0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_datain", datain, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sys_arr_feeder.md
SYS_ARR_FEEDER -- requirements
Module: sys_arr_feeder

Interface
REQ-001 SHALL have parameter width_height, default 4, the systolic array dimension W (rows = columns = lanes).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, begins one weight-load-then-stream job when the block is in IDLE.
REQ-005 SHALL have port wvalid, input, 1, weight row offered.
REQ-006 SHALL have port wrow, input, 8*W, weight row with lane i in bits [8i+7:8i].
REQ-007 SHALL have port wready, output, 1, weight row accepted on any edge where wvalid and wready are both high.
REQ-008 SHALL have port dvalid, input, 1, data vector offered.
REQ-009 SHALL have port drow, input, 8*W, data vector with lane i in bits [8i+7:8i].
REQ-010 SHALL have port dlast, input, 1, marks the final data vector of the job; qualified by a data acceptance.
REQ-011 SHALL have port dready, output, 1, data vector accepted on any edge where dvalid and dready are both high.
REQ-012 SHALL have port win, output, 8*W, weight bus to the array.
REQ-013 SHALL have port wwrite, output, W, per-column weight write enables to the array.
REQ-014 SHALL have port datain, output, 8*W, skewed data bus to the array.
REQ-015 SHALL have port active, output, 1, array compute enable.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at job completion.

Function
REQ-018 SHALL implement the states IDLE, LOAD_W, STREAM and DRAIN.
REQ-019 SHALL transition from IDLE to LOAD_W on an edge where start is high; start SHALL be ignored in every other state.
REQ-020 SHALL hold wready high only in LOAD_W and count accepted weight rows with a log2(W)+1-bit counter cleared on entry to LOAD_W.
REQ-021 SHALL transition from LOAD_W to STREAM on the edge accepting the W-th row; wvalid gaps SHALL stall the count without error.
REQ-022 SHALL register each accepted wrow onto win and drive wwrite all-ones for exactly the cycle following acceptance; otherwise wwrite SHALL be zero and win SHALL hold its last value.
REQ-023 SHALL hold dready high only in STREAM.
REQ-024 SHALL use a per-lane skew pipeline in which lane i of an accepted vector appears on datain lane i exactly 1+i cycles after the accepting edge; lane 0 is therefore delayed 1 cycle and lane W-1 is delayed W cycles.
REQ-025 SHALL carry a valid bit alongside each lane stage, and lanes with a clear valid bit SHALL drive 0x00 on datain.
REQ-026 SHALL, when dvalid is low in STREAM, insert a bubble (valid=0, data zero) into the skew pipeline so lane alignment is preserved.
REQ-027 SHALL register active as the OR of all lane output valid bits; for N back-to-back vectors, active is high for N+W-1 consecutive cycles.
REQ-028 SHALL transition from STREAM to DRAIN on the edge accepting a vector with dlast high.
REQ-029 SHALL, in DRAIN, shift bubbles for W cycles, then pulse done for one cycle and return to IDLE on the same edge.
REQ-030 SHALL treat a dlast on the first accepted vector as a valid one-vector job.
REQ-031 SHALL allow start to be high on the same edge that IDLE is re-entered and accept it on the following cycle; the skew pipeline SHALL already be empty at that point.

Reset
REQ-032 SHALL, while reset is high, force the state to IDLE, clear all counters and skew stages, and drive win, wwrite, datain, active, busy, done, wready and dready to zero, independent of clk.
REQ-033 SHALL, on reset asserted mid-job, discard all in-flight data and weights, with no done pulse generated.

Verification
REQ-034 SHALL verify reset: assert reset mid-STREAM -> all outputs 0 immediately (before next edge); IDLE after release.
REQ-035 SHALL verify weight load with W=4: start, then rows 0x04040404, 0x03030303, 0x02020202, 0x01010101 back-to-back -> win follows them one cycle later, wwrite=4'b1111 for 4 cycles, state STREAM after the 4th.
REQ-036 SHALL verify skew: 4 vectors of 0x01010101 back-to-back with dlast on the 4th -> datain sequence 0x00000001, 0x00000101, 0x00010101, 0x01010101, 0x01010100, 0x01010000, 0x01000000, then 0; active high exactly those 7 cycles.
REQ-037 SHALL verify a bubble: dvalid low for one cycle between two vectors -> a zero diagonal appears in datain at the matching skewed positions; active stays high through the gap.
REQ-038 SHALL verify completion: done pulses once, exactly W cycles after the dlast acceptance; busy falls on the same edge; a start during STREAM is ignored.
REQ-039 SHALL verify a one-vector job: dlast on the first vector -> active high for W cycles, followed by done.
